// File: rtl/mul_pkg.sv
// ============================================================================
// mul_pkg : shared types and defaults for the multiplier arbiter slice
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int XLEN_DEF    = 32;
  localparam int TIMEOUT_DEF = 96;
  localparam int PROD_W      = 2 * XLEN_DEF;

endpackage

`default_nettype wire

// File: rtl/mul_arbiter_rr.sv
// ============================================================================
// rr_arbiter : combinational round-robin grant, search starts at ptr and wraps
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N    = 4,
  parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] idx
);

  int   j;
  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDXW'(j);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mul_arbiter.sv
// ============================================================================
// mul_arbiter : shares one iterative multiplier among NREQ requesters
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module mul_arbiter
  import mul_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int XLEN    = XLEN_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 mul_clk,
  input  logic                 resetn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XLEN-1:0] req_x,
  input  logic [NREQ*XLEN-1:0] req_y,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [2*XLEN-1:0]    resp_result,
  output logic                 resp_err,
  output logic                 mul,
  output logic [XLEN-1:0]      mul_x,
  output logic [XLEN-1:0]      mul_y,
  input  logic                 mul_complete,
  input  logic [2*XLEN-1:0]    mul_result,
  output logic                 busy
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e              state_q, state_d;
  logic [IDXW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0]     owner_q, owner_d;
  logic [7:0]          timer_q, timer_d;
  logic [XLEN-1:0]     mul_x_q, mul_x_d;
  logic [XLEN-1:0]     mul_y_q, mul_y_d;
  logic [2*XLEN-1:0]   result_q, result_d;
  logic                err_q, err_d;

  logic [NREQ-1:0]     gnt;
  logic [IDXW-1:0]     gnt_idx;
  logic                req_hs;

  rr_arbiter #(.N(NREQ), .IDXW(IDXW)) u_rr (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  // Gated by resetn so no grant is offered while reset is held.
  assign req_ready = (state_q == ST_IDLE && resetn) ? gnt : '0;
  assign req_hs    = |(req_valid & req_ready);

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      resp_valid[i] = (state_q == ST_RESP) && (owner_q == IDXW'(i));
    end
  end

  assign mul         = (state_q == ST_RUN);
  assign busy        = (state_q != ST_IDLE);
  assign mul_x       = mul_x_q;
  assign mul_y       = mul_y_q;
  assign resp_result = result_q;
  assign resp_err    = err_q;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    timer_d  = timer_q;
    mul_x_d  = mul_x_q;
    mul_y_d  = mul_y_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_hs) begin
          owner_d  = gnt_idx;
          mul_x_d  = req_x[gnt_idx*XLEN +: XLEN];
          mul_y_d  = req_y[gnt_idx*XLEN +: XLEN];
          rr_ptr_d = (gnt_idx == IDXW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
          timer_d  = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        timer_d = timer_q + 8'd1;
        // Completion takes priority over a simultaneous timeout.
        if (mul_complete) begin
          result_d = mul_result;
          err_d    = 1'b0;
          state_d  = ST_RESP;
        end else if (timer_q == 8'(TIMEOUT-1)) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready[owner_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge mul_clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      timer_q  <= '0;
      mul_x_q  <= '0;
      mul_y_q  <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      timer_q  <= timer_d;
      mul_x_q  <= mul_x_d;
      mul_y_q  <= mul_y_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

endmodule

`default_nettype wire
